// File: rtl/dmem_arbiter_if.sv
// One requester port of dmem_arbiter: request/operation from the requester,
// grant/ack/read-data/error back from the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input gnt, ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port (core C, loader/DMA D) sequencer in front of a single-port data memory.
// DMEM_ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of C-over-D priority.
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     c_if,
    dmem_arbiter_if.slave     d_if,
    output logic              c_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ERR, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              win_d_q, win_d_d;     // current winner is D
    logic              last_d_q, last_d_d;   // previous grant went to D
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic              c_gnt_q, c_gnt_d, d_gnt_q, d_gnt_d;
    logic              c_ack_q, c_ack_d, d_ack_q, d_ack_d;
    logic              c_err_q, c_err_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic              pick_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign pick_d = d_if.req & (~c_if.req | ~last_d_q);
`else
    assign pick_d = d_if.req & ~c_if.req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        win_d_d   = win_d_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        c_gnt_d   = 1'b0;
        d_gnt_d   = 1'b0;
        c_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        c_err_d   = c_err_q;
        d_err_d   = d_err_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (c_if.req | d_if.req) begin
                    win_d_d  = pick_d;
                    last_d_d = pick_d;
                    we_d     = pick_d ? d_if.we    : c_if.we;
                    addr_d   = pick_d ? d_if.addr  : c_if.addr;
                    wdata_d  = pick_d ? d_if.wdata : c_if.wdata;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    c_gnt_d  = ~pick_d;
                    d_gnt_d  = pick_d;
                    if (addr_d[1:0] != 2'b00) begin
                        state_d = ERR;
                    end else begin
                        state_d  = BUSY;
                        mem_rd_d = ~we_d;
                        // with no wait states the first BUSY cycle is also the commit cycle
                        mem_wr_d = we_d & (WAIT_CYCLES == 0);
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_rd_d = ~we_q;
                    mem_wr_d = we_q & (cnt_d == '0);
                end else begin
                    state_d = DONE;
                    if (win_d_q) begin
                        d_ack_d = 1'b1;
                        d_err_d = 1'b0;
                        if (!we_q) d_rdata_d = mem_rdata;
                    end else begin
                        c_ack_d = 1'b1;
                        c_err_d = 1'b0;
                        if (!we_q) c_rdata_d = mem_rdata;
                    end
                end
            end
            ERR: begin
                state_d = DONE;
                if (win_d_q) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = 1'b1;
                    d_rdata_d = '0;
                end else begin
                    c_ack_d   = 1'b1;
                    c_err_d   = 1'b1;
                    c_rdata_d = '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            win_d_q   <= 1'b0;
            last_d_q  <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            c_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            win_d_q   <= win_d_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            c_gnt_q   <= c_gnt_d;
            d_gnt_q   <= d_gnt_d;
            c_ack_q   <= c_ack_d;
            d_ack_q   <= d_ack_d;
            c_err_q   <= c_err_d;
            d_err_q   <= d_err_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign c_if.gnt   = c_gnt_q;
    assign c_if.ack   = c_ack_q;
    assign c_if.err   = c_err_q;
    assign c_if.rdata = c_rdata_q;
    assign d_if.gnt   = d_gnt_q;
    assign d_if.ack   = d_ack_q;
    assign d_if.err   = d_err_q;
    assign d_if.rdata = d_rdata_q;
    assign c_stall    = c_if.req & ~c_if.ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps plus random traffic scored against a
// transaction-level memory model (accesses applied in acknowledge order).
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_stall, mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cif ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .c_if(cif), .d_if(dif), .c_stall(c_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // The physical memory behind the arbiter: combinational read, write at the edge.
    logic [DW-1:0] mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;

    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_rd [2];
    op_t           cur [2];
    bit            act [2];
    op_t           cq[$], dq[$];
    int            ack_order[$];
    int            vec = 0, err_n = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        op_t o;
        o.we = we; o.addr = a; o.wdata = wd;
        return o;
    endfunction

    task automatic set_port(input bit p, input logic r, input op_t o);
        if (p) begin
            dif.req = r; dif.we = o.we; dif.addr = o.addr; dif.wdata = o.wdata;
        end else begin
            cif.req = r; cif.we = o.we; cif.addr = o.addr; cif.wdata = o.wdata;
        end
    endtask

    // Scoreboard: each acknowledge completes the port's current operation.
    task automatic score(input bit p);
        op_t           o;
        bit            e;
        logic [DW-1:0] er;
        o = cur[p];
        e = (o.addr[1:0] != 2'b00);
        if (e)          er = '0;
        else if (!o.we) er = ref_mem[o.addr[7:2]];
        else            er = exp_rd[p];
        if (!e && o.we) ref_mem[o.addr[7:2]] = o.wdata;
        exp_rd[p] = er;
        chk(p ? "d_rdata" : "c_rdata", p ? dif.rdata : cif.rdata, er);
        chk(p ? "d_err" : "c_err", 32'(p ? dif.err : cif.err), 32'(e));
        ack_order.push_back(int'(p));
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("c_stall", 32'(c_stall), 32'(cif.req & ~cif.ack));
            chk("c_quiet", 32'((cif.gnt | cif.ack) & ~act[0]), 32'(0));
            chk("d_quiet", 32'((dif.gnt | dif.ack) & ~act[1]), 32'(0));
            chk("one_ack", 32'(cif.ack & dif.ack), 32'(0));
            if (cif.ack) score(1'b0);
            if (dif.ack) score(1'b1);
        end
    end

    // Presents the port's queued operations back to back; optionally times each one.
    task automatic drive_port(input bit p, input int delay, input bit chk_lat);
        op_t o;
        int  cyc, gat, wr_n, rd_n;
        bit  got, al;
        o = mk(1'b0, '0, '0);
        repeat (delay) @(negedge clk);
        @(negedge clk);
        act[p] = 1'b1;
        while ((p ? dq.size() : cq.size()) != 0) begin
            o = p ? dq.pop_front() : cq.pop_front();
            cur[p] = o;
            set_port(p, 1'b1, o);
            cyc = 0; gat = 0; wr_n = 0; rd_n = 0; got = 1'b0;
            while (!got && cyc < 40) begin
                @(posedge clk); #1; cyc++;
                if ((p ? dif.gnt : cif.gnt) && gat == 0) gat = cyc;
                wr_n += int'(mem_wr);
                rd_n += int'(mem_rd);
                got = p ? dif.ack : cif.ack;
            end
            if (!got) chk("ack_timeout", 32'(0), 32'(1));
            al = (o.addr[1:0] == 2'b00);
            if (chk_lat) begin
                chk("gnt_cycle", gat, 1);
                chk("ack_latency", cyc, al ? W + 2 : 2);
                chk("wr_strobes", wr_n, (al && o.we) ? 1 : 0);
                chk("rd_cycles", rd_n, (al && !o.we) ? W + 1 : 0);
            end
            @(negedge clk);
        end
        set_port(p, 1'b0, o);
        act[p] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        logic [AW-1:0] a;
        logic [3:0]    ord, exp_ord;
        set_port(1'b0, 1'b0, mk(1'b0, '0, '0));
        set_port(1'b1, 1'b0, mk(1'b0, '0, '0));
        act[0] = 1'b0; act[1] = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        mem[8] <= 32'h12345678;
        ref_mem[8] = 32'h12345678;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_c_gnt", 32'(cif.gnt), 32'(0));
        chk("rst_c_ack", 32'(cif.ack), 32'(0));
        chk("rst_c_err", 32'(cif.err), 32'(0));
        chk("rst_c_rdata", cif.rdata, 32'(0));
        chk("rst_d_gnt", 32'(dif.gnt), 32'(0));
        chk("rst_d_ack", 32'(dif.ack), 32'(0));
        chk("rst_d_err", 32'(dif.err), 32'(0));
        chk("rst_d_rdata", dif.rdata, 32'(0));
        chk("rst_mem_rd", 32'(mem_rd), 32'(0));
        chk("rst_mem_wr", 32'(mem_wr), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'(0));
        chk("rst_mem_wdata", mem_wdata, 32'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;

        // core write then read back
        cq.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
        drive_port(1'b0, 0, 1'b1);
        cq.push_back(mk(1'b0, 32'h10, '0));
        drive_port(1'b0, 0, 1'b1);
        chk("c_read_back", cif.rdata, 32'hDEADBEEF);
        chk("c_read_err", 32'(cif.err), 32'(0));

        // DMA read of preloaded word
        dq.push_back(mk(1'b0, 32'h20, '0));
        drive_port(1'b1, 0, 1'b1);
        chk("d_preload", dif.rdata, 32'h12345678);

        // misaligned core read
        cq.push_back(mk(1'b0, 32'h13, '0));
        drive_port(1'b0, 0, 1'b1);
        chk("mis_err", 32'(cif.err), 32'(1));
        chk("mis_rdata", cif.rdata, 32'(0));

        // reset in the middle of a write
        @(negedge clk);
        act[0] = 1'b1;
        cur[0] = mk(1'b1, 32'h80, 32'hCAFEF00D);
        set_port(1'b0, 1'b1, cur[0]);
        @(posedge clk); #1;
        chk("busy_addr", mem_addr, 32'h80);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(mem_wr), 32'(0));
        chk("mid_rst_rd", 32'(mem_rd), 32'(0));
        chk("mid_rst_gnt", 32'(cif.gnt), 32'(0));
        chk("mid_rst_ack", 32'(cif.ack), 32'(0));
        chk("mid_rst_addr", mem_addr, 32'(0));
        chk("mid_rst_rdata", cif.rdata, 32'(0));
        set_port(1'b0, 1'b0, cur[0]);
        act[0] = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_no_commit", mem[32], ref_mem[32]);

        // simultaneous requests, two each, straight after reset
        ack_order.delete();
        cq.push_back(mk(1'b1, 32'h00, 32'h11111111));
        cq.push_back(mk(1'b0, 32'h44, '0));
        dq.push_back(mk(1'b0, 32'h10, '0));
        dq.push_back(mk(1'b1, 32'h48, 32'h22222222));
        fork
            drive_port(1'b0, 0, 1'b0);
            drive_port(1'b1, 0, 1'b0);
        join
        chk("arb_count", ack_order.size(), 4);
        ord = '0;
        for (int i = 0; i < 4 && i < ack_order.size(); i++) ord[3-i] = ack_order[i][0];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_ord = 4'b0101;
`else
        exp_ord = 4'b0011;
`endif
        chk("arb_order", 32'(ord), 32'(exp_ord));

        // the location hit by the interrupted write keeps its old data
        cq.push_back(mk(1'b0, 32'h80, '0));
        drive_port(1'b0, 0, 1'b1);

        // DMA write, core read of the same word queued behind it
        dq.push_back(mk(1'b1, 32'h40, 32'hA5A5A5A5));
        cq.push_back(mk(1'b0, 32'h40, '0));
        fork
            drive_port(1'b1, 0, 1'b0);
            drive_port(1'b0, 1, 1'b0);
        join
        chk("c_after_d_wr", cif.rdata, 32'hA5A5A5A5);

        // random single-port traffic with timing checks
        for (int n = 0; n < 40; n++) begin
            a = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) dq.push_back(mk(1'($urandom), a, $urandom));
            else                           cq.push_back(mk(1'($urandom), a, $urandom));
            drive_port(dq.size() != 0, 0, 1'b1);
        end

        // random contention
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 1 + int'($urandom_range(0, 1)); k++) begin
                a = 32'($urandom_range(0, 15)) << 2;
                cq.push_back(mk(1'($urandom), a, $urandom));
                a = 32'($urandom_range(0, 15)) << 2;
                dq.push_back(mk(1'($urandom), a, $urandom));
            end
            fork
                drive_port(1'b0, int'($urandom_range(0, 2)), 1'b0);
                drive_port(1'b1, int'($urandom_range(0, 2)), 1'b0);
            join
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err_n);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequencing controller and two-port arbiter in front of the single-port data memory used by the memory-access stage.
- Shares the memory between the core MA stage (port C) and a loader/DMA port (port D).
- Serialises accesses, inserts programmable wait states, and returns read data with a one-cycle acknowledge.
- Drives the memory's read strobe, write strobe, address and write-data inputs.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, extra BUSY cycles per access; 0 is legal.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- c_req  input  1  core request; held until c_ack.
- c_we  input  1  core write (1) / read (0).
- c_addr  input  ADDR_W  core byte address.
- c_wdata  input  DATA_W  core write data.
- c_gnt  output  1  one-cycle pulse: core request accepted.
- c_ack  output  1  one-cycle pulse: core access complete.
- c_rdata  output  DATA_W  core read data, valid while c_ack=1.
- c_err  output  1  misaligned access flag, valid while c_ack=1.
- d_req, d_we, d_addr, d_wdata, d_gnt, d_ack, d_rdata, d_err: same directions, widths and meanings as the core signals, for the DMA port.
- c_stall  output  1  combinational: c_req & ~c_ack; feeds the pipeline stall.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data (combinational read).

Behaviour:
- Reset: state=IDLE, cnt=0, all gnt/ack/err/mem_rd/mem_wr=0, rdata regs=0, mem_addr/mem_wdata=0, last_winner=D (so C wins the first tie).
- FSM states:
  - IDLE: at an edge with c_req|d_req, select the winner and latch we/addr/wdata. Next state is BUSY, or ERR if addr[1:0]≠0. cnt←WAIT_CYCLES. The winner's gnt is high for the following cycle.
  - BUSY: mem_addr and mem_wdata are driven from the latched values. mem_rd=~we during all BUSY cycles. mem_wr=we only in the BUSY cycle where cnt==0, so exactly one write strobe per access. cnt decrements each edge while nonzero. At the edge with cnt==0: capture mem_rdata into the winner's rdata reg (reads only) and go to DONE.
  - ERR: memory is never strobed. Winner's rdata←0 and err←1. Go to DONE.
  - DONE: winner's ack=1 for exactly this cycle. The err flag is valid alongside ack. Return to IDLE; no arbitration happens in DONE.
- Latency, request seen to ack high: WAIT_CYCLES+2 cycles (2 for ERR). Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- Handshake: requester holds req/we/addr/wdata stable until ack, then deasserts or re-presents req the cycle after ack. The controller ignores port inputs outside IDLE; the latched operation always completes even if req drops.
- rdata and err hold their value until that port's next DONE. ack, gnt and err never assert on the non-winning port.
- Arbitration (default, no macro): fixed priority, C beats D on simultaneous requests. last_winner still updates on every grant.
- Write on port X followed by read on port Y to the same address: Y sees the new data.
- Reset mid-access: immediate return to IDLE, strobes drop asynchronously. A write is not committed unless its commit edge preceded reset. No ack is issued.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous c_req and d_req in IDLE, the port that is not last_winner is granted, so neither port starves. A single requester is always granted.
- Undefined: fixed C-over-D priority as above; last_winner is unused for decisions.

Test Plan:
- WAIT_CYCLES=1. Core write addr 0x10, data 0xDEADBEEF, then core read 0x10 → c_gnt 1 cycle after req seen, mem_wr high exactly 1 cycle, c_ack at req+3, read returns c_rdata=0xDEADBEEF, c_err=0.
- WAIT_CYCLES=0. D read of 0x20 preloaded with 0x12345678 → d_ack 2 cycles after req, d_rdata=0x12345678, no c_gnt/c_ack activity.
- Simultaneous c_req and d_req held for two accesses → without macro C served twice before D; with DMEM_ARB_ROUND_ROBIN_EN the order is C then D. c_stall stays high until c_ack.
- Core read at addr 0x13 → no mem_rd/mem_wr, c_ack 2 cycles later with c_err=1 and c_rdata=0.
- Assert rst_n=0 during BUSY of a write with WAIT_CYCLES=3 → all outputs 0 immediately, memory location unchanged, no ack. A later access completes normally.
- D writes 0xA5A5A5A5 to 0x40 while C queues a read of 0x40 → C read returns 0xA5A5A5A5.
